// File: rtl/contador_bcd_4dig.sv
// Four-digit BCD up/down counter fed by two raw push-buttons (sync, debounce, rising-edge detect).
// Optional CONTADOR_BCD_SATURA_EN: clamp at 9999/0000 instead of wrapping; o_Carry then stays 0.
module contador_bcd_4dig #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEB_W           = 20
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Btn_Up,
  input  logic       i_Btn_Down,
  input  logic       i_Clr,
  output logic [3:0] o_Datos1,
  output logic [3:0] o_Datos2,
  output logic [3:0] o_Datos3,
  output logic [3:0] o_Datos4,
  output logic       o_Carry
);

  // Index 0 = up button, index 1 = down button.
  logic [1:0]       w_btn_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [1:0]       r_deb_d;
  logic [DEB_W-1:0] r_deb_cnt [2];
  logic [1:0]       w_pulse;

  logic [15:0]      r_val;
  logic             r_carry;
  logic [15:0]      w_inc;
  logic [15:0]      w_dec;
  logic             w_inc_c;
  logic             w_dec_b;

  assign w_btn_raw = {i_Btn_Down, i_Btn_Up};
  assign w_pulse   = r_deb & ~r_deb_d;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Ripple carry/borrow across nibbles; final w_inc_c/w_dec_b flag a wrap.
  always_comb begin
    w_inc   = r_val;
    w_dec   = r_val;
    w_inc_c = 1'b1;
    w_dec_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_inc_c) begin
        if (r_val[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_val[4*i +: 4] + 4'd1;
          w_inc_c         = 1'b0;
        end
      end
      if (w_dec_b) begin
        if (r_val[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_val[4*i +: 4] - 4'd1;
          w_dec_b         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_val   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (i_Clr) begin
        r_val <= '0;
      end else if (w_pulse[0] && w_pulse[1]) begin
        r_val <= r_val;
      end else if (w_pulse[0]) begin
`ifdef CONTADOR_BCD_SATURA_EN
        if (!w_inc_c) r_val <= w_inc;
`else
        r_val   <= w_inc;
        r_carry <= w_inc_c;
`endif
      end else if (w_pulse[1]) begin
`ifdef CONTADOR_BCD_SATURA_EN
        if (!w_dec_b) r_val <= w_dec;
`else
        r_val   <= w_dec;
        r_carry <= w_dec_b;
`endif
      end
    end
  end

  assign o_Datos1 = r_val[3:0];
  assign o_Datos2 = r_val[7:4];
  assign o_Datos3 = r_val[11:8];
  assign o_Datos4 = r_val[15:12];
  assign o_Carry  = r_carry;

endmodule

// File: tb/tb_contador_bcd_4dig.sv
// Directed bench for contador_bcd_4dig with DEBOUNCE_CYCLES=4 (7-edge press latency).
module tb_contador_bcd_4dig;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up;
  logic       btn_dn;
  logic       clr;
  logic [3:0] d1, d2, d3, d4;
  logic       carry;
  logic [15:0] value;

  int n_vec = 0;
  int n_err = 0;
  int carry_cnt = 0;

  typedef struct {
    logic        up;
    logic        dn;
    logic [15:0] exp_val;
    int          exp_carries;
  } vec_t;

  vec_t tbl [9];

  contador_bcd_4dig #(.DEBOUNCE_CYCLES(4), .DEB_W(20)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst_n),
    .i_Btn_Up   (btn_up),
    .i_Btn_Down (btn_dn),
    .i_Clr      (clr),
    .o_Datos1   (d1),
    .o_Datos2   (d2),
    .o_Datos3   (d3),
    .o_Datos4   (d4),
    .o_Carry    (carry)
  );

  always #5 clk = ~clk;

  assign value = {d4, d3, d2, d1};

  always @(negedge clk) if (carry) carry_cnt++;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d);
    btn_up = u;
    btn_dn = d;
    cyc(10);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    cyc(10);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    int c0;
`ifdef CONTADOR_BCD_SATURA_EN
    tbl[0] = '{1'b0, 1'b1, 16'h0000, 0};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 0};
    tbl[2] = '{1'b1, 1'b0, 16'h0001, 0};
    tbl[3] = '{1'b0, 1'b1, 16'h0000, 0};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 0};
    tbl[5] = '{1'b1, 1'b0, 16'h0001, 0};
    tbl[6] = '{1'b1, 1'b1, 16'h0001, 0};
    tbl[7] = '{1'b1, 1'b0, 16'h0002, 0};
    tbl[8] = '{1'b1, 1'b0, 16'h0003, 0};
`else
    tbl[0] = '{1'b0, 1'b1, 16'h0000, 0};
    tbl[1] = '{1'b0, 1'b1, 16'h9999, 1};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 1};
    tbl[3] = '{1'b0, 1'b1, 16'h9999, 1};
    tbl[4] = '{1'b0, 1'b1, 16'h9998, 0};
    tbl[5] = '{1'b1, 1'b0, 16'h9999, 0};
    tbl[6] = '{1'b1, 1'b1, 16'h9999, 0};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 1};
    tbl[8] = '{1'b1, 1'b0, 16'h0001, 0};
`endif

    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    clr    = 1'b0;
    cyc(2);
    chk("reset_digits", value, 16'h0000);
    chk("reset_carry", {15'd0, carry}, 16'h0000);
    rst_n = 1'b1;
    cyc(2);

    // Short 3-cycle glitches must never be accepted.
    for (int i = 0; i < 10; i++) begin
      btn_up = 1'b1;
      cyc(3);
      btn_up = 1'b0;
      cyc(10);
    end
    chk("glitch_reject", value, 16'h0000);

    // Held button: count appears on edge 7, once only.
    btn_up = 1'b1;
    cyc(6);
    chk("hold_edge6", value, 16'h0000);
    cyc(1);
    chk("hold_edge7", value, 16'h0001);
    cyc(13);
    chk("hold_edge20", value, 16'h0001);
    btn_up = 1'b0;
    cyc(10);

    for (int i = 0; i < 9; i++) begin
      c0 = carry_cnt;
      press(tbl[i].up, tbl[i].dn);
      chk($sformatf("vec%0d_value", i), value, tbl[i].exp_val);
      chk($sformatf("vec%0d_carry", i), 16'(carry_cnt - c0), 16'(tbl[i].exp_carries));
    end

    pulse_clr();
    chk("clr_level", value, 16'h0000);

    for (int i = 0; i < 42; i++) press(1'b1, 1'b0);
    chk("load_0042", value, 16'h0042);
    press(1'b1, 1'b1);
    chk("both_0042", value, 16'h0042);

    // Clear lands on the same edge as up_p.
    btn_up = 1'b1;
    cyc(6);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_vs_up", value, 16'h0000);
    cyc(4);
    btn_up = 1'b0;
    cyc(10);
    chk("clr_vs_up_after", value, 16'h0000);

    for (int i = 0; i < 123; i++) press(1'b1, 1'b0);
    chk("load_0123", value, 16'h0123);

    // Async reset with the debounce counter at 2, button kept held.
    btn_up = 1'b1;
    cyc(4);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", value, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    chk("rst_rel_edge6", value, 16'h0000);
    cyc(1);
    chk("rst_rel_edge7", value, 16'h0001);
    btn_up = 1'b0;
    cyc(10);

    pulse_clr();
    for (int i = 0; i < 999; i++) press(1'b1, 1'b0);
    chk("load_0999", value, 16'h0999);
    c0 = carry_cnt;
    press(1'b1, 1'b0);
    chk("ripple_1000", value, 16'h1000);
    chk("ripple_no_carry", 16'(carry_cnt - c0), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/contador_bcd_4dig.md
Name: contador_bcd_4dig

Overview:
- Four-digit BCD up/down counter driven by two push-buttons, with synchronisation, debounce and edge detection built in.
- Produces the four 4-bit digit nibbles consumed by the 7-segment display controller's i_Datos1..i_Datos4 inputs.
- Sits directly upstream of that controller.
- Shares its clock and reset.

Parameters:
- DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a button change is accepted. Legal range 2..2^20-1.
- DEB_W, default 20: width of each debounce counter. Must satisfy 2^DEB_W > DEBOUNCE_CYCLES.

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst  input  1  reset, asynchronous, active-low.
- i_Btn_Up  input  1  raw increment button, active-high, asynchronous to i_Clk.
- i_Btn_Down  input  1  raw decrement button, active-high, asynchronous to i_Clk.
- i_Clr  input  1  synchronous clear, already synchronous to i_Clk, level-sensitive.
- o_Datos1  output  4  BCD units digit.
- o_Datos2  output  4  BCD tens digit.
- o_Datos3  output  4  BCD hundreds digit.
- o_Datos4  output  4  BCD thousands digit.
- o_Carry  output  1  one-cycle pulse on wrap 9999->0000 or 0000->9999.

Behaviour:
- Reset (i_Rst=0, asynchronous):
  - all digits = 0, o_Carry = 0;
  - synchronisers, debounced states and debounce counters = 0.
  - Reset is asserted asynchronously and released synchronously into the logic; no partial count survives.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - Counter increments while the synchronised value differs from the debounced state.
  - Counter clears to 0 whenever the values match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while differing, the debounced state toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced state.
- Edge detect: a 0->1 transition of the debounced state produces a 1-cycle internal pulse (up_p / dn_p). Releases produce nothing.
- Latency: the digits change on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples the raw button high, given the button stays high.
- Counter, evaluated each cycle in priority order:
  1. i_Clr=1: all digits -> 0; o_Carry = 0; pulses that cycle are discarded.
  2. up_p and dn_p both high: no change.
  3. up_p: BCD increment with ripple carry.
     - A digit at 9 goes to 0 and carries into the next digit.
     - 9999 -> 0000 with o_Carry = 1 for one cycle.
  4. dn_p: BCD decrement with ripple borrow.
     - A digit at 0 goes to 9 and borrows from the next digit.
     - 0000 -> 9999 with o_Carry = 1 for one cycle.
- Digits never hold values 10..15. Outputs are registered.
- A held button gives exactly one count. Auto-repeat is not supported.
- Reset mid-debounce: the pending press is lost. After release, the button must again be stable for DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: CONTADOR_BCD_SATURA_EN.
- Defined:
  - increment at 9999 holds 9999;
  - decrement at 0000 holds 0000;
  - o_Carry is tied to 0.
- Not defined: wrap-around behaviour as specified above, with o_Carry pulses.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then hold i_Btn_Up high for 20 cycles -> o_Datos4..1 = 0,0,0,1 exactly 7 edges after the first sampled high; remains 0001 while held.
- i_Btn_Up pulses high for 3 cycles, 10 times, with gaps of 10 cycles -> count stays 0000 (glitch rejection).
- Load 0999 by 999 clean presses (or force), then one Up press -> digits 1,0,0,0; o_Carry stays 0.
- At 9999, one Up press -> 0000 and o_Carry high for exactly 1 cycle; at 0000, one Down press -> 9999 and o_Carry pulses. With CONTADOR_BCD_SATURA_EN: stays at 9999 / 0000 respectively, o_Carry = 0.
- Both buttons pressed simultaneously from 0042 -> remains 0042. i_Clr=1 on the same cycle as an up_p at 0042 -> 0000.
- Assert i_Rst=0 asynchronously mid-debounce (counter at 2) at value 0123 -> outputs 0000 immediately, without waiting for a clock edge. After release with the button still held, the increment arrives 7 edges later -> 0001.
